reverse_bits_serial_rx: RTL
===========================

# reverse_bits_serial_rx

Serial receiver at the far end of the bit-reversal path. It takes framed bytes from a one-bit line sent LSB-first, reassembles each byte, and presents it on a valid/ready output port. Each byte appears twice on that port: once as received (`q`) and once bit-reversed (`w`). It sits between the serial line interface and the parallel consumers that the bit-reversal datapath already feeds.

## Interface
- `DATA_W`, default 8: data bits per frame; legal range 2..16.
- `clk`  input  1  system clock; all state updates on the rising edge.
- `rst_n`  input  1  asynchronous, active-low reset.
- `bit_en`  input  1  bit-rate strobe; `sin` is sampled only on cycles where `bit_en`=1.
- `sin`  input  1  serial line; idles high.
- `out_ready`  input  1  consumer accepts the word when `out_valid`=1.
- `out_valid`  output  1  `q`/`w` hold an unconsumed word.
- `q`  output  DATA_W  received word; the first data bit is `q[0]`.
- `w`  output  DATA_W  bit-reversed `q`: `w[DATA_W-1-i]` = `q[i]`.
- `frame_err`  output  1  one-cycle pulse: stop bit sampled low.
- `overrun`  output  1  one-cycle pulse: a good frame was dropped because the output was still full.

## Operation
- Frame format: start bit (0), then DATA_W data bits LSB-first, then stop bit (1). One bit per `bit_en` strobe.
- FSM states: IDLE, DATA, STOP.
  - IDLE: on `bit_en` with `sin`=0, go to DATA and clear the bit counter. `sin`=1 stays in IDLE.
  - DATA: on each `bit_en`, shift `sin` into the shift register at position `count`. The counter runs 0..DATA_W-1. After the bit at `count`=DATA_W-1, go to STOP.
  - STOP: on `bit_en` with `sin`=1, the frame is good; go to IDLE. With `sin`=0, pulse `frame_err`, discard the frame, and go to IDLE. This idle-wait also covers the case where a new start bit directly follows.
- Output register on a good frame:
  - If `out_valid`=0, or `out_valid`=1 and `out_ready`=1 in the same cycle: load `q` with the assembled word and `w` with its reversal, and set `out_valid`=1.
  - Otherwise, pulse `overrun`, drop the new word, and leave `q`/`w` unchanged.
- Consume: when `out_valid`=1, `out_ready`=1 and no good frame completes that cycle, `out_valid` clears on that edge.
- `q`/`w` are stable whenever `out_valid`=1 and change only on a load.
- Cycles with `bit_en`=0 make no FSM, counter or shift progress. `out_ready` handling continues on every cycle.
- The counter is ceil(log2(DATA_W)) bits wide and has no wrap: it leaves DATA on the last bit.
- `w` is pure wiring of the loaded `q` and is registered together with it.

## Timing
- Reset (async assert, sync-free release):
  - FSM=IDLE, counter=0, shift register=0.
  - `out_valid`=0, `q`=0, `w`=0, `frame_err`=0, `overrun`=0.
- Reset asserted mid-frame: the partial frame is discarded, any pending output word is lost, and the next frame must begin with a fresh start bit.
- Latency: the output loads on the clock edge that samples a good stop bit. `out_valid`, `q` and `w` are visible in the following cycle. That is DATA_W+2 `bit_en` strobes after the start-bit strobe edge.
- `frame_err` and `overrun` go high for exactly one cycle, registered at the stop-bit edge.
- Back-to-back frames (a start bit on the strobe right after the stop bit) are received with no lost strobes.
- A frame error never touches `out_valid`, `q` or `w`.
- The output is single-entry: no buffering beyond the one word.

## Test plan
- Reset: hold `rst_n`=0 with `sin` toggling -> all outputs 0, and no frame is detected after release until a start bit.
- `bit_en`=1 every cycle, frame 0x2D (line sequence 0,1,0,1,1,0,1,0,0,1), `out_ready`=0 -> `out_valid`=1 at cycle 11, `q`=0x2D, `w`=0xB4, held. Then raise `out_ready` for one cycle -> `out_valid`=0.
- `bit_en` every 4th cycle, frame 0x01 -> `q`=0x01, `w`=0x80, latency 10 strobes. No progress on non-strobe cycles.
- Stop bit 0 on frame 0x0F -> one-cycle `frame_err`, `out_valid` stays 0. The next frame, 0xA5, gives `q`=`w`=0xA5.
- 0x0F pending with `out_ready`=0, then frame 0x3C completes -> one-cycle `overrun`, `q`=0x0F, `w`=0xF0 retained. Repeat with `out_ready`=1 on the stop edge -> no overrun, `q`=0x3C, `w`=0x3C, `out_valid` stays 1.
- Assert `rst_n`=0 after 4 data bits -> outputs 0 immediately, FSM in IDLE. A following full frame 0x80 gives `q`=0x80, `w`=0x01.

Source files
------------

// File: rtl/reverse_bits_serial_rx.sv
// Serial receiver: reassembles LSB-first framed words from a 1-bit line
// and presents each word as received (q) and bit-reversed (w).
module reverse_bits_serial_rx #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              bit_en,
    input  logic              sin,
    input  logic              out_ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] q,
    output logic [DATA_W-1:0] w,
    output logic              frame_err,
    output logic              overrun
);

    localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DATA = 2'd1,
        STOP = 2'd2
    } state_t;

    state_t            state;
    state_t            state_nx;
    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  cnt_nx;
    logic [DATA_W-1:0] shreg;
    logic [DATA_W-1:0] shreg_nx;
    logic              good;
    logic              bad;
    logic              load;
    logic              drop;
    logic              valid_nx;
    logic [DATA_W-1:0] rev;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
            shreg <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            shreg <= shreg_nx;
        end
    end

    // Nothing advances unless the bit-rate strobe is present.
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        shreg_nx = shreg;
        good     = 1'b0;
        bad      = 1'b0;
        if (bit_en) begin
            unique case (state)
                IDLE: begin
                    if (!sin) begin
                        state_nx = DATA;
                        cnt_nx   = '0;
                    end
                end
                DATA: begin
                    shreg_nx[cnt] = sin;
                    if (cnt == CNT_LAST) begin
                        state_nx = STOP;
                    end else begin
                        cnt_nx = cnt + CNT_W'(1);
                    end
                end
                STOP: begin
                    state_nx = IDLE;
                    if (sin) begin
                        good = 1'b1;
                    end else begin
                        bad = 1'b1;
                    end
                end
                default: begin
                    state_nx = IDLE;
                end
            endcase
        end
    end

    always_comb begin
        rev = '0;
        for (int i = 0; i < DATA_W; i++) begin
            rev[DATA_W-1-i] = shreg[i];
        end
    end

    // A completing frame may reuse the slot in the same cycle it drains.
    always_comb begin
        load     = good && (!out_valid || out_ready);
        drop     = good && out_valid && !out_ready;
        valid_nx = out_valid;
        if (load) begin
            valid_nx = 1'b1;
        end else if (out_valid && out_ready) begin
            valid_nx = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            q         <= '0;
            w         <= '0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            out_valid <= valid_nx;
            frame_err <= bad;
            overrun   <= drop;
            if (load) begin
                q <= shreg;
                w <= rev;
            end
        end
    end

endmodule
